// File: rtl/idct_sched_pkg.sv
// Shared types for the IDCT block scheduler: FSM states, the 8x8 coefficient
// block type and the requester-index to channel-code mapping.
package idct_sched_pkg;

    typedef enum logic [1:0] {IDLE, GAP, DRAIN, DONE} sched_state_t;

    typedef logic signed [11:0] coef_t;
    typedef coef_t [7:0][7:0] coef_blk_t;

    // Channel code 0 is reserved for "no block", so requester i maps to i+1.
    function automatic int unsigned chan_code(input int unsigned idx);
        return idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-wide round-robin arbiter. The priority pointer is owned by the caller,
// so the same arbiter can serve any shared resource with its own update rule.
module rr_arbiter #(
    parameter int unsigned N = 3,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic          en_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          gnt_valid_o
);

    logic [IW-1:0] idx;

    // Scan upward from ptr_i with wrap-around; the first active request wins.
    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        idx         = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = IW'((32'(ptr_i) + off) % N);
            if (en_i && !gnt_valid_o && req_i[idx]) begin
                gnt_o[idx]  = 1'b1;
                gnt_idx_o   = idx;
                gnt_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/idct_block_scheduler.sv
// Issues 8x8 coefficient blocks from CH requesters into the 2D IDCT with
// round-robin fairness, a minimum issue spacing and an in-flight credit limit.
// Provides a flush/drain handshake for end-of-frame.
// Optional build macro IDCT_SCHED_PERF_EN adds saturating performance counters.
module idct_block_scheduler
    import idct_sched_pkg::*;
#(
    parameter int unsigned CH           = 3,
    parameter int unsigned ISSUE_GAP    = 10,
    parameter int unsigned MAX_INFLIGHT = 4,
    localparam int unsigned CHW = $clog2(CH + 1),
    localparam int unsigned IFW = $clog2(MAX_INFLIGHT + 1),
    localparam int unsigned PW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH-1:0]        req_valid,
    output logic [CH-1:0]        req_ready,
    input  coef_blk_t [CH-1:0]   req_block,
    output logic                 idct_valid_in,
    output logic [CHW-1:0]       idct_channel_in,
    output coef_blk_t            idct_block_in,
    input  logic                 idct_valid_out,
    input  logic                 flush,
    output logic                 flush_done,
    output logic [IFW-1:0]       inflight,
    output logic                 busy,
    output logic                 err_underflow
`ifdef IDCT_SCHED_PERF_EN
    ,
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_credit_stall,
    output logic [31:0]          perf_gap_stall
`endif
);

    sched_state_t   state_q, state_d;
    logic [3:0]     gap_cnt_q, gap_cnt_d;
    logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IFW-1:0] inflight_q, inflight_d;
    logic           err_q, err_d;
    logic           valid_q, valid_d;
    logic [CHW-1:0] chan_q, chan_d;
    coef_blk_t      blk_q, blk_d;
    logic           done_q, done_d;
    // Set on DRAIN entry, cleared once flush drops: makes flush edge-triggered.
    logic           flush_arm_q, flush_arm_d;

    logic           grant_ok, hs, comp;
    logic [PW-1:0]  gnt_idx;

    // Grants are withheld during reset so no requester sees a lost handshake.
    assign grant_ok = !rst && (state_q == IDLE) && (inflight_q < IFW'(MAX_INFLIGHT)) &&
                      !flush && (|req_valid);
    assign comp     = idct_valid_out && (inflight_q != '0);

    rr_arbiter #(
        .N (CH)
    ) u_arb (
        .req_i       (req_valid),
        .en_i        (grant_ok),
        .ptr_i       (rr_ptr_q),
        .gnt_o       (req_ready),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (hs)
    );

    // Next-state: credits, issue registers, arbitration pointer and FSM.
    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        inflight_d  = inflight_q;
        err_d       = err_q | (idct_valid_out && (inflight_q == '0));
        valid_d     = hs;
        chan_d      = '0;
        blk_d       = blk_q;
        done_d      = 1'b0;
        flush_arm_d = flush & flush_arm_q;

        if (hs && !comp) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!hs && comp) begin
            inflight_d = inflight_q - 1'b1;
        end

        if (hs) begin
            rr_ptr_d = (gnt_idx == PW'(CH - 1)) ? '0 : gnt_idx + 1'b1;
            chan_d   = CHW'(chan_code(32'(gnt_idx)));
            blk_d    = req_block[gnt_idx];
        end

        unique case (state_q)
            IDLE, GAP: begin
                if (flush && !flush_arm_q) begin
                    state_d     = DRAIN;
                    flush_arm_d = 1'b1;
                end else if (hs) begin
                    if (ISSUE_GAP > 1) begin
                        state_d   = GAP;
                        gap_cnt_d = 4'(ISSUE_GAP - 1);
                    end
                end else if (state_q == GAP) begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                    if (gap_cnt_q == 4'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            // Look at the post-completion count so flush_done follows the last
            // completion by exactly one cycle.
            DRAIN: begin
                if (inflight_d == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gap_cnt_q   <= '0;
            rr_ptr_q    <= '0;
            inflight_q  <= '0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
            chan_q      <= '0;
            blk_q       <= '0;
            done_q      <= 1'b0;
            flush_arm_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            inflight_q  <= inflight_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
            chan_q      <= chan_d;
            blk_q       <= blk_d;
            done_q      <= done_d;
            flush_arm_q <= flush_arm_d;
        end
    end

    assign idct_valid_in   = valid_q;
    assign idct_channel_in = chan_q;
    assign idct_block_in   = blk_q;
    assign flush_done      = done_q;
    assign inflight        = inflight_q;
    assign busy            = (inflight_q != '0) || (state_q != IDLE);
    assign err_underflow   = err_q;

`ifdef IDCT_SCHED_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_credit_q, perf_credit_d;
    logic [31:0] perf_gap_q, perf_gap_d;

    // Saturating event counters.
    always_comb begin
        perf_issued_d = perf_issued_q;
        perf_credit_d = perf_credit_q;
        perf_gap_d    = perf_gap_q;
        if (hs && (perf_issued_q != '1)) begin
            perf_issued_d = perf_issued_q + 32'd1;
        end
        if ((|req_valid) && (inflight_q == IFW'(MAX_INFLIGHT)) && (perf_credit_q != '1)) begin
            perf_credit_d = perf_credit_q + 32'd1;
        end
        if ((|req_valid) && (state_q == GAP) && (perf_gap_q != '1)) begin
            perf_gap_d = perf_gap_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued_q <= '0;
            perf_credit_q <= '0;
            perf_gap_q    <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_credit_q <= perf_credit_d;
            perf_gap_q    <= perf_gap_d;
        end
    end

    assign perf_issued       = perf_issued_q;
    assign perf_credit_stall = perf_credit_q;
    assign perf_gap_stall    = perf_gap_q;
`endif

endmodule

// File: tb/tb_idct_block_scheduler.sv
// Self-checking bench for idct_block_scheduler (CH=3, ISSUE_GAP=10, MAX_INFLIGHT=4).
module tb_idct_block_scheduler;
    import idct_sched_pkg::*;

    localparam int GAP  = 10;
    localparam int MAXI = 4;

    logic            clk, rst;
    logic [2:0]      req_valid, req_ready;
    coef_blk_t [2:0] req_block;
    logic            idct_valid_in;
    logic [1:0]      idct_channel_in;
    coef_blk_t       idct_block_in;
    logic            idct_valid_out, flush, flush_done, busy, err_underflow;
    logic [2:0]      inflight;
`ifdef IDCT_SCHED_PERF_EN
    logic [31:0]     perf_issued, perf_credit_stall, perf_gap_stall;
`endif

    idct_block_scheduler #(.CH(3), .ISSUE_GAP(GAP), .MAX_INFLIGHT(MAXI)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_block       (req_block),
        .idct_valid_in   (idct_valid_in),
        .idct_channel_in (idct_channel_in),
        .idct_block_in   (idct_block_in),
        .idct_valid_out  (idct_valid_out),
        .flush           (flush),
        .flush_done      (flush_done),
        .inflight        (inflight),
        .busy            (busy),
        .err_underflow   (err_underflow)
`ifdef IDCT_SCHED_PERF_EN
        ,
        .perf_issued       (perf_issued),
        .perf_credit_stall (perf_credit_stall),
        .perf_gap_stall    (perf_gap_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    typedef struct {
        logic [2:0] v;
        logic [2:0] gnt;
        logic [1:0] ch;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [767:0] act, input logic [767:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic coef_blk_t const_blk(input int v);
        coef_blk_t b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) b[r][c] = 12'(v);
        return b;
    endfunction

    function automatic coef_blk_t pat(input int seed);
        coef_blk_t b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) b[r][c] = 12'(seed * 64 + r * 8 + c);
        return b;
    endfunction

    function automatic coef_blk_t rand_blk();
        coef_blk_t b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) b[r][c] = 12'($urandom);
        return b;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        idct_valid_out = 1'b0;
        flush = 1'b0;
        tick();
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", idct_valid_in, 0);
        chk("rst_chan", idct_channel_in, 0);
        chk("rst_block", idct_block_in, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_underflow, 0);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "timeout");
    end

    int cnt, got, grants, pulses;
    int t_iss [6];
    int ch_iss [6];
    // Reference model state
    int m_inf, m_rr, m_mode, m_last, cyc, g, n_inf, flen;
    bit m_arm, n_arm, e_valid, e_done;
    int e_chan;
    logic [2:0] pend, exp_rdy;
    coef_blk_t e_blk;
    coef_blk_t rblk [3];

    initial begin
        rst = 1'b1; req_valid = '0; req_block = '0; idct_valid_out = 1'b0; flush = 1'b0;
        tbl[0] = '{3'b001, 3'b001, 2'd1};
        tbl[1] = '{3'b111, 3'b010, 2'd2};
        tbl[2] = '{3'b011, 3'b001, 2'd1};
        tbl[3] = '{3'b101, 3'b100, 2'd3};
        tbl[4] = '{3'b110, 3'b010, 2'd2};
        tbl[5] = '{3'b010, 3'b010, 2'd2};
        tbl[6] = '{3'b111, 3'b100, 2'd3};
        tbl[7] = '{3'b000, 3'b000, 2'd0};
        tbl[8] = '{3'b100, 3'b100, 2'd3};
        tbl[9] = '{3'b011, 3'b001, 2'd1};

        // Single block through the pipe
        do_reset();
        req_block[0] = const_blk(5);
        req_valid = 3'b001;
        #1;
        chk("single_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        chk("single_valid", idct_valid_in, 1);
        chk("single_chan", idct_channel_in, 1);
        chk("single_data", idct_block_in, const_blk(5));
        chk("single_inflight", inflight, 1);
        chk("single_busy", busy, 1);
        tick();
        chk("single_valid_drop", idct_valid_in, 0);
        chk("single_chan_zero", idct_channel_in, 0);
        chk("single_data_hold", idct_block_in, const_blk(5));
        idct_valid_out = 1'b1;
        tick();
        idct_valid_out = 1'b0;
        chk("single_inflight_0", inflight, 0);
        repeat (GAP) tick();
        chk("single_busy_drop", busy, 0);

        // Table-driven arbitration vectors, pointer starts at 0
        do_reset();
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 3; i++) req_block[i] = pat(k * 3 + i);
            req_valid = tbl[k].v;
            #1;
            chk($sformatf("tbl%0d_ready", k), req_ready, tbl[k].gnt);
            tick();
            req_valid = '0;
            chk($sformatf("tbl%0d_valid", k), idct_valid_in, (tbl[k].gnt != 0));
            chk($sformatf("tbl%0d_chan", k), idct_channel_in, tbl[k].ch);
            if (tbl[k].ch != 0) begin
                chk($sformatf("tbl%0d_data", k), idct_block_in, pat(k * 3 + tbl[k].ch - 1));
                idct_valid_out = 1'b1;
                tick();
                idct_valid_out = 1'b0;
                repeat (GAP) tick();
            end
            chk($sformatf("tbl%0d_inflight", k), inflight, 0);
        end

        // Round robin with continuous demand: order and spacing
        do_reset();
        for (int i = 0; i < 3; i++) req_block[i] = pat(100 + i);
        req_valid = 3'b111;
        cnt = 0;
        for (int c = 0; c < 200 && cnt < 6; c++) begin
            tick();
            idct_valid_out = idct_valid_in;
            if (idct_valid_in) begin
                t_iss[cnt] = c;
                ch_iss[cnt] = int'(idct_channel_in);
                cnt++;
            end
        end
        req_valid = '0;
        tick();
        idct_valid_out = 1'b0;
        chk("rr_count", cnt, 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rr_chan%0d", k), ch_iss[k], k % 3 + 1);
            if (k > 0) chk($sformatf("rr_gap%0d", k), t_iss[k] - t_iss[k-1], GAP);
        end
        chk("rr_inflight", inflight, 0);

        // Credit limit
        do_reset();
        req_valid = 3'b111;
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (idct_valid_in) cnt++;
        end
        chk("credit_issues", cnt, MAXI);
        chk("credit_inflight", inflight, MAXI);
        chk("credit_ready_blocked", req_ready, 0);
        idct_valid_out = 1'b1;
        tick();
        idct_valid_out = 1'b0;
        got = 0;
        for (int c = 0; c < 2 && got == 0; c++) begin
            tick();
            if (idct_valid_in) got = 1;
        end
        chk("credit_reissue", got, 1);
        chk("credit_inflight_after", inflight, MAXI);

        // Simultaneous issue and completion at inflight 2, then underflow
        do_reset();
        req_valid = 3'b001;
        cnt = 0;
        got = 0;
        for (int c = 0; c < 100 && got == 0; c++) begin
            #1;
            if (req_ready != 0) begin
                cnt++;
                if (cnt == 3) begin
                    idct_valid_out = 1'b1;
                    got = 1;
                end
            end
            tick();
        end
        idct_valid_out = 1'b0;
        req_valid = '0;
        chk("sim_found", got, 1);
        chk("sim_inflight", inflight, 2);
        idct_valid_out = 1'b1;
        tick();
        tick();
        idct_valid_out = 1'b0;
        chk("uf_inflight_0", inflight, 0);
        chk("uf_err_clear", err_underflow, 0);
        idct_valid_out = 1'b1;
        tick();
        idct_valid_out = 1'b0;
        chk("uf_err_set", err_underflow, 1);
        chk("uf_inflight_stays", inflight, 0);
        repeat (5) tick();
        chk("uf_err_sticky", err_underflow, 1);

        // Flush with three blocks in flight
        do_reset();
        req_valid = 3'b111;
        cnt = 0;
        for (int c = 0; c < 100 && cnt < 3; c++) begin
            #1;
            if (req_ready != 0) cnt++;
            tick();
        end
        chk("flush_setup", inflight, 3);
        flush = 1'b1;
        grants = 0;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            repeat (4) begin
                #1;
                if (req_ready != 0) grants++;
                if (flush_done) pulses++;
                tick();
            end
            idct_valid_out = 1'b1;
            tick();
            idct_valid_out = 1'b0;
        end
        chk("flush_done_pulse", flush_done, 1);
        for (int c = 0; c < 15; c++) begin
            tick();
            if (flush_done) pulses++;
            #1;
            if (req_ready != 0) grants++;
        end
        chk("flush_no_grants", grants, 0);
        chk("flush_single_pulse", pulses, 0);
        chk("flush_busy_idle", busy, 0);
        flush = 1'b0;
        #1;
        chk("flush_release", req_ready, 3'b001);
        tick();
        req_valid = '0;

        // Reset in the middle of GAP with two blocks in flight
        do_reset();
        req_valid = 3'b001;
        cnt = 0;
        for (int c = 0; c < 100 && cnt < 2; c++) begin
            #1;
            if (req_ready != 0) cnt++;
            tick();
        end
        req_valid = '0;
        tick();
        tick();
        chk("midgap_inflight", inflight, 2);
        chk("midgap_busy", busy, 1);
        do_reset();
        req_block[1] = pat(77);
        req_valid = 3'b010;
        #1;
        chk("post_rst_ready", req_ready, 3'b010);
        tick();
        req_valid = '0;
        chk("post_rst_valid", idct_valid_in, 1);
        chk("post_rst_chan", idct_channel_in, 2);
        chk("post_rst_data", idct_block_in, pat(77));

        // Randomized run against a time-based reference model
        do_reset();
        m_inf = 0; m_rr = 0; m_mode = 0; m_arm = 0; m_last = -1000; cyc = 0;
        e_valid = 0; e_chan = 0; e_blk = '0; e_done = 0; pend = '0; flen = 0;
        for (int i = 0; i < 3; i++) rblk[i] = '0;
        for (int n = 0; n < 3000; n++) begin
            chk("rnd_valid", idct_valid_in, e_valid);
            chk("rnd_chan", idct_channel_in, e_chan);
            if (e_valid) chk("rnd_data", idct_block_in, e_blk);
            chk("rnd_flush_done", flush_done, e_done);
            chk("rnd_inflight", inflight, m_inf);
            chk("rnd_busy", busy, (m_inf != 0) || (m_mode != 0) || (cyc - m_last < GAP));
            chk("rnd_err", err_underflow, 0);

            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    rblk[i] = rand_blk();
                end
                req_block[i] = rblk[i];
            end
            req_valid = pend;
            if (flen > 0) flen--;
            else if ($urandom_range(0, 149) == 0) flen = $urandom_range(1, 25);
            flush = (flen > 0);
            idct_valid_out = (m_inf > 0) &&
                             ($urandom_range(0, ((n / 400) % 2 != 0) ? 3 : 40) == 0);
            #1;

            g = -1;
            if (!flush && m_mode == 0 && (cyc - m_last >= GAP) && m_inf < MAXI)
                for (int off = 0; off < 3; off++)
                    if (g < 0 && pend[(m_rr + off) % 3]) g = (m_rr + off) % 3;
            exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
            chk("rnd_ready", req_ready, exp_rdy);

            n_inf = m_inf + ((g >= 0) ? 1 : 0) - (idct_valid_out ? 1 : 0);
            e_valid = (g >= 0);
            e_chan = (g >= 0) ? g + 1 : 0;
            e_done = 0;
            if (g >= 0) begin
                e_blk = rblk[g];
                pend[g] = 1'b0;
                m_rr = (g + 1) % 3;
                m_last = cyc;
            end
            n_arm = flush && m_arm;
            case (m_mode)
                0: if (flush && !m_arm) begin
                    m_mode = 1;
                    n_arm = 1;
                    m_last = -1000;
                end
                1: if (n_inf == 0) begin
                    m_mode = 2;
                    e_done = 1;
                end
                default: m_mode = 0;
            endcase
            m_arm = n_arm;
            m_inf = n_inf;
            cyc++;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
